// File: rtl/alu_pipe.sv
// Single-issue ALU with one result register stage and valid/ready handshake on both sides.
// Define ALU_PIPE_MUL_EN to make opcode 1111 a WIDTH-cycle shift-add multiply.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOTA = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_DEC  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_PASS = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;
  } res_t;

  // Signed overflow of a + b: operands agree in sign, sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic res_t alu_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [3:0] op, input logic cin);
    res_t                    r;
    logic        [WIDTH-1:0] addb;
    logic                    addc;
    logic        [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SHW-1:0]   amt;
    r    = '0;
    a_s  = a;
    b_s  = b;
    amt  = b[SHW-1:0];
    addb = b;
    addc = cin;
    // Subtract and decrement reuse the adder; carry-out then reads as no-borrow.
    case (op)
      OP_SUB:  begin addb = ~b;               addc = 1'b1; end
      OP_INC:  begin addb = '0;               addc = 1'b1; end
      OP_DEC:  begin addb = {WIDTH{1'b1}};    addc = 1'b0; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, addb} + {{WIDTH{1'b0}}, addc};
    case (op)
      OP_AND:  r.y = a & b;
      OP_OR:   r.y = a | b;
      OP_NOTA: r.y = ~a;
      OP_NOR:  r.y = ~(a | b);
      OP_XOR:  r.y = a ^ b;
      OP_NAND: r.y = ~(a & b);
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        r.y    = sum[WIDTH-1:0];
        r.cout = sum[WIDTH];
        r.ovf  = add_ovf(a[WIDTH-1], addb[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SLL:  r.y = a << amt;
      OP_SRL:  r.y = a >> amt;
      OP_SRA:  r.y = a_s >>> amt;
      OP_PASS: r.y = a;
      OP_SLT:  r.y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: begin
        r.y   = '0;
        r.ovf = 1'b1;
      end
    endcase
    return r;
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] y_p1;
  logic             cout_p1;
  logic             neg_p1;
  logic             zero_p1;
  logic             ovf_p1;
  logic             accept;
  res_t             res_p0;

  assign res_p0 = alu_op(A, B, sel, Cin);
  assign accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;
  logic               mul_done;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == MUL) && (cnt == SHW'(WIDTH - 1));
  assign busy     = (state == MUL);
  assign in_ready = (state == IDLE) && (!vld_p1 || out_ready);
`else
  assign busy     = 1'b0;
  assign in_ready = !vld_p1 || out_ready;
`endif

  // Stage p0 -> p1: result registers and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      y_p1    <= '0;
      cout_p1 <= 1'b0;
      neg_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else begin
`ifdef ALU_PIPE_MUL_EN
      if (accept && sel == OP_MUL) begin
        state  <= MUL;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, A};
        mplier <= B;
        vld_p1 <= 1'b0;
      end else if (accept) begin
`else
      if (accept) begin
`endif
        vld_p1  <= 1'b1;
        y_p1    <= res_p0.y;
        cout_p1 <= res_p0.cout;
        neg_p1  <= res_p0.y[WIDTH-1];
        zero_p1 <= (res_p0.y == '0);
        ovf_p1  <= res_p0.ovf;
`ifdef ALU_PIPE_MUL_EN
      end else if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_done) begin
          state   <= IDLE;
          vld_p1  <= 1'b1;
          y_p1    <= acc_next[WIDTH-1:0];
          cout_p1 <= 1'b0;
          neg_p1  <= acc_next[WIDTH-1];
          zero_p1 <= (acc_next[WIDTH-1:0] == '0);
          ovf_p1  <= |acc_next[2*WIDTH-1:WIDTH];
        end
`endif
      end else if (vld_p1 && out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign Y         = y_p1;
  assign Cout      = cout_p1;
  assign Negative  = neg_p1;
  assign Zero      = zero_p1;
  assign Overflow  = ovf_p1;

endmodule
